// File: rtl/multi_filter_if.sv
// Signal bundle between a multi-channel input filter and its consumer.
interface multi_filter_if #(
    parameter int CHANNELS = 4
);
    logic                enable;
    logic [CHANNELS-1:0] sig_in;
    logic [CHANNELS-1:0] sig_out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] glitch;

    modport master (
        output enable,
        output sig_in,
        input  sig_out,
        input  rise,
        input  fall,
        input  glitch
    );

    modport slave (
        input  enable,
        input  sig_in,
        output sig_out,
        output rise,
        output fall,
        output glitch
    );
endinterface

// File: rtl/multi_filter.sv
// Multi-channel debounce/deglitch filter. Each channel is optionally
// synchronised, then its output only follows a new level once that level
// has been seen for STABLE_CYCLES consecutive enabled edges. Registered
// one-cycle pulses flag output edges and aborted pending changes.
module multi_filter #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int SYNC_STAGES   = 2,
    parameter bit RESET_VALUE   = 1'b0
) (
    input  logic          clock,
    input  logic          reset,
    multi_filter_if.slave bus
);
    localparam int            CW      = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] rise_q;
    logic [CHANNELS-1:0] fall_q;
    logic [CHANNELS-1:0] glitch_q;
    logic [CW-1:0]       cnt_q [CHANNELS];

    if (SYNC_STAGES == 0) begin : g_nosync
        assign s = bus.sig_in;
    end else begin : g_sync
        logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

        // Synchroniser chain: shifts on every edge, independent of enable.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= {CHANNELS{RESET_VALUE}};
                end
            end else begin
                sync_q[0] <= bus.sig_in;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_q[k] <= sync_q[k-1];
                end
            end
        end

        assign s = sync_q[SYNC_STAGES-1];
    end

    // Per-channel stability counter, filtered level and event pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
            out_q    <= {CHANNELS{RESET_VALUE}};
            rise_q   <= '0;
            fall_q   <= '0;
            glitch_q <= '0;
        end else begin
            rise_q   <= '0;
            fall_q   <= '0;
            glitch_q <= '0;
            if (bus.enable) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (s[i] == out_q[i]) begin
                        // A pending change that did not last is reported as a glitch.
                        if (cnt_q[i] != '0) begin
                            cnt_q[i]    <= '0;
                            glitch_q[i] <= 1'b1;
                        end
                    end else if (cnt_q[i] == CNT_MAX) begin
                        cnt_q[i]  <= '0;
                        out_q[i]  <= s[i];
                        rise_q[i] <= s[i];
                        fall_q[i] <= ~s[i];
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.sig_out = out_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;
    assign bus.glitch  = glitch_q;
endmodule

// File: tb/tb_multi_filter.sv
// Bench for multi_filter with default parameters: per-edge vector table
// checked through a scoreboard queue, plus hand-built reset sequences.
module tb_multi_filter;
    typedef struct {
        logic       en;
        logic [3:0] din;
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] glitch;
        string      name;
    } vec_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    vec_t vecs[$];
    vec_t sb[$];

    multi_filter_if #(.CHANNELS(4)) mf ();

    multi_filter #(
        .CHANNELS     (4),
        .STABLE_CYCLES(3),
        .SYNC_STAGES  (2),
        .RESET_VALUE  (1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (mf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void cmp(input string name, input string field,
                                input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%b expected=%b at t=%0t", name, field, act, exp, $time);
        end
    endfunction

    function automatic void check_all(input string name, input logic [3:0] out,
                                      input logic [3:0] rise, input logic [3:0] fall,
                                      input logic [3:0] glitch);
        cmp(name, "sig_out", mf.sig_out, out);
        cmp(name, "rise",    mf.rise,    rise);
        cmp(name, "fall",    mf.fall,    fall);
        cmp(name, "glitch",  mf.glitch,  glitch);
    endfunction

    task automatic add(input int n, input logic en, input logic [3:0] din,
                       input logic [3:0] out, input logic [3:0] rise,
                       input logic [3:0] fall, input logic [3:0] glitch,
                       input string name);
        vec_t v;
        v.en = en; v.din = din; v.out = out;
        v.rise = rise; v.fall = fall; v.glitch = glitch; v.name = name;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    // Drive one row before the next rising edge, then compare just after it.
    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        mf.enable = v.en;
        mf.sig_in = v.din;
        sb.push_back(v);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty actual=0 expected=1 entries");
        end else begin
            e = sb.pop_front();
            check_all(e.name, e.out, e.rise, e.fall, e.glitch);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        mf.enable = 1'b1;
        mf.sig_in = 4'b0000;

        // Step on channel 0: output after 2 sync + 3 stable edges.
        add(4, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "stepA_count");
        add(1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "stepA_rise");
        add(1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "stepA_hold");
        add(4, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "stepA_back");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "stepA_fall");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "stepA_idle");
        // Two-sample pulse on channel 1 aborts at cnt=2.
        add(2, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitchB_hi");
        add(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitchB_lo");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, "glitchB_pulse");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitchB_idle");
        // Single-sample pulse on channel 3 aborts at cnt=1.
        add(1, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitchE_hi");
        add(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitchE_lo");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, "glitchE_pulse");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "glitchE_idle");
        // Two channels change together, the others stay put.
        add(4, 1, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "indepC_count");
        add(1, 1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, 4'b0000, "indepC_rise");
        add(1, 1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 4'b0000, "indepC_hold");
        add(4, 1, 4'b0000, 4'b1010, 4'b0000, 4'b0000, 4'b0000, "indepC_back");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 4'b0000, "indepC_fall");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "indepC_idle");
        // Freeze channel 2 mid-count; counting resumes from the held value.
        add(3, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeD_count");
        add(3, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeD_frozen");
        add(1, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeD_resume");
        add(1, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, "freezeD_rise");
        add(1, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "freezeD_hold");
        add(4, 1, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, "freezeD_back");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, "freezeD_fall");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeD_idle");
        // Abort happens while frozen: glitch waits for the first enabled edge.
        add(2, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeG_hi");
        add(2, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeG_lo");
        add(2, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeG_noglitch");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, "freezeG_glitch");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "freezeG_idle");
        // Glitch on channel 3 and rise on channel 0 on neighbouring edges.
        add(1, 1, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "mixF_start");
        add(2, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "mixF_count");
        add(1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, "mixF_glitch");
        add(1, 1, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, "mixF_rise");
        add(1, 1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "mixF_hold");
        add(4, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, "mixF_back");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, "mixF_fall");
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "mixF_idle");

        // Asynchronous reset between edges.
        #3 reset = 1'b0;
        #1 check_all("reset_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b1;
        @(posedge clock);
        #1 check_all("reset_release", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Reset in the middle of a count on channel 3 clears counter and sync.
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v.en = 1'b1; v.din = 4'b1000; v.out = 4'b0000;
            v.rise = 4'b0000; v.fall = 4'b0000; v.glitch = 4'b0000;
            v.name = "rstmid_pre";
            apply(v);
        end
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check_all("rstmid_low", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #5 reset = 1'b1;
        #1 check_all("rstmid_released", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v.en = 1'b1; v.din = 4'b1000;
            v.out  = (i == 4) ? 4'b1000 : 4'b0000;
            v.rise = (i == 4) ? 4'b1000 : 4'b0000;
            v.fall = 4'b0000; v.glitch = 4'b0000;
            v.name = (i == 4) ? "rstmid_rise" : "rstmid_recount";
            apply(v);
        end

        // Async reset with sig_out high clears it without an edge or fall pulse.
        @(negedge clock);
        mf.sig_in = 4'b0000;
        reset = 1'b0;
        #1 check_all("rsthigh_async", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vec_t v;
            v.en = 1'b1; v.din = 4'b0000; v.out = 4'b0000;
            v.rise = 4'b0000; v.fall = 4'b0000; v.glitch = 4'b0000;
            v.name = "rsthigh_after";
            apply(v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
